// File: rtl/pdu_pkg.sv
// Shared constants for the processor debug unit: IO bus map, CPU-clock
// FSM states and display view modes.
package pdu_pkg;

    localparam int unsigned IO_AW      = 8;
    localparam int unsigned NSTEP_W    = 8;
    localparam int unsigned ADDR_CNT_W = 5;

    // IO bus register map
    localparam logic [IO_AW-1:0] IO_OUT0    = 8'h00;
    localparam logic [IO_AW-1:0] IO_READY   = 8'h04;
    localparam logic [IO_AW-1:0] IO_OUT1    = 8'h08;
    localparam logic [IO_AW-1:0] IO_IN      = 8'h0c;
    localparam logic [IO_AW-1:0] IO_VALID   = 8'h10;
    localparam logic [IO_AW-1:0] IO_BP_ADDR = 8'h14;
    localparam logic [IO_AW-1:0] IO_BP_CTRL = 8'h18;
    localparam logic [IO_AW-1:0] IO_CYC     = 8'h1c;
    localparam logic [IO_AW-1:0] IO_NSTEP   = 8'h20;

    // CPU clock generator states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HALT = 2'd3
    } state_t;

    // Display view modes
    localparam logic [1:0] VIEW_IO  = 2'b00;
    localparam logic [1:0] VIEW_RF  = 2'b01;
    localparam logic [1:0] VIEW_MEM = 2'b10;
    localparam logic [1:0] VIEW_CH  = 2'b11;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser with edge detection for board inputs.
// Ports: clk, rst_n; d = raw asynchronous inputs;
//        lvl = synchronised level, rise_c = rising edge, any_c = either edge.
module edge_sync #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] lvl,
    output logic [W-1:0] rise_c,
    output logic [W-1:0] any_c
);

    logic [W-1:0] s1, s2, s3;

    // s1/s2 synchronise; s3 holds the previous synchronised value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign lvl    = s2;
    assign rise_c = s2 & ~s3;
    assign any_c  = s2 ^ s3;

endmodule

// File: rtl/pdu_bp.sv
// Processor debug unit: CPU clock generation (run / N-step / breakpoint halt),
// memory-mapped IO bus, CPU cycle counter and scanned hex display of the IO
// register, RF, memory or one of NCH debug channels.
// Ports: clk, rst_n; run/step/valid/in board inputs; clk_cpu, halted to CPU/LED;
//        check view mode; out0, ready LEDs; an/seg display scan; io_* IO bus;
//        m_rf_addr/rf_data/m_data debug access; pc fetch PC; dbg_bus channels.
module pdu_bp
    import pdu_pkg::*;
#(
    parameter int unsigned DW        = 32,
    parameter int unsigned NCH       = 16,
    parameter int unsigned NDIG      = 8,
    parameter int unsigned SCAN_BITS = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run,
    input  logic                     step,
    input  logic                     valid,
    input  logic [4:0]               in,
    output logic                     clk_cpu,
    output logic                     halted,
    output logic [1:0]               check,
    output logic [4:0]               out0,
    output logic                     ready,
    output logic [$clog2(NDIG)-1:0]  an,
    output logic [3:0]               seg,
    input  logic [IO_AW-1:0]         io_addr,
    input  logic [DW-1:0]            io_dout,
    input  logic                     io_we,
    output logic [DW-1:0]            io_din,
    output logic [7:0]               m_rf_addr,
    input  logic [DW-1:0]            rf_data,
    input  logic [DW-1:0]            m_data,
    input  logic [DW-1:0]            pc,
    input  logic [NCH*DW-1:0]        dbg_bus
);

    localparam int unsigned AW   = $clog2(NDIG);
    localparam int unsigned CW   = $clog2(NCH);
    localparam int unsigned PADW = (1 << AW) * 4;

    if (NDIG * 4 < DW) begin : g_bad_ndig
        $error("pdu_bp: NDIG*4 must be at least DW");
    end
    if (NCH < 2) begin : g_bad_nch
        $error("pdu_bp: NCH must be at least 2");
    end

    // Input synchronisation: bit 0 run, 1 step, 2 valid, 7:3 in
    logic [7:0] sync_lvl, sync_rise, sync_any;

    edge_sync #(.W(8)) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      ({in, valid, step, run}),
        .lvl    (sync_lvl),
        .rise_c (sync_rise),
        .any_c  (sync_any)
    );

    logic       run_s, step_p, valid_s, valid_pn, next_pn, prev_pn;
    logic [4:0] in_sync;
    logic       unused_sync;

    assign run_s    = sync_lvl[0];
    assign valid_s  = sync_lvl[2];
    assign in_sync  = sync_lvl[7:3];
    assign step_p   = sync_rise[1];
    assign valid_pn = sync_any[2];
    assign next_pn  = sync_any[3];
    assign prev_pn  = sync_any[4];
    assign unused_sync = ^{sync_lvl[1], sync_rise[7:2], sync_rise[0],
                           sync_any[7:5], sync_any[1:0]};

    // IO-visible registers
    logic [4:0]          out0_r;
    logic [DW-1:0]       out1_r, bp_addr, cyc_cnt;
    logic                bp_en;
    logic [NSTEP_W-1:0]  nstep;

    // CPU clock FSM
    state_t              state_q, state_d;
    logic                clk_cpu_d, halted_d, skip_q, skip_d, bp_hit_c, cpu_rise_c;
    logic [NSTEP_W-1:0]  rem_q, rem_d;

    // skip masks a breakpoint match until the CPU has been clocked once
    assign bp_hit_c   = bp_en && (pc == bp_addr) && !skip_q;
    assign cpu_rise_c = !clk_cpu && clk_cpu_d;

    always_comb begin
        state_d   = state_q;
        clk_cpu_d = 1'b0;
        skip_d    = skip_q;
        rem_d     = rem_q;
        case (state_q)
            IDLE: begin
                if (run_s) begin
                    state_d = RUN;
                    skip_d  = 1'b1;
                end else if (step_p) begin
                    state_d = STEP;
                    skip_d  = 1'b1;
                    rem_d   = (nstep == '0) ? NSTEP_W'(1) : nstep;
                end
            end
            RUN: begin
                if (!run_s) begin
                    state_d = IDLE;
                end else if (clk_cpu) begin
                    if (bp_hit_c) state_d = HALT;
                end else begin
                    clk_cpu_d = 1'b1;
                    skip_d    = 1'b0;
                end
            end
            STEP: begin
                if (clk_cpu) begin
                    rem_d = rem_q - NSTEP_W'(1);
                    if (bp_hit_c)                  state_d = HALT;
                    else if (rem_q == NSTEP_W'(1)) state_d = IDLE;
                end else begin
                    clk_cpu_d = 1'b1;
                    skip_d    = 1'b0;
                end
            end
            HALT: begin
                if (!run_s && !step_p) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            clk_cpu <= 1'b0;
            halted  <= 1'b0;
            skip_q  <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            clk_cpu <= clk_cpu_d;
            halted  <= halted_d;
            skip_q  <= skip_d;
            rem_q   <= rem_d;
        end
    end

    // IO register writes; a cycle-counter clear beats a same-clock increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out0_r  <= 5'h1f;
            ready   <= 1'b1;
            out1_r  <= DW'(32'h1234_5678);
            bp_addr <= '0;
            bp_en   <= 1'b0;
            nstep   <= NSTEP_W'(1);
            cyc_cnt <= '0;
        end else begin
            if (io_we) begin
                case (io_addr)
                    IO_OUT0:    out0_r  <= io_dout[4:0];
                    IO_READY:   ready   <= io_dout[0];
                    IO_OUT1:    out1_r  <= io_dout;
                    IO_BP_ADDR: bp_addr <= io_dout;
                    IO_BP_CTRL: bp_en   <= io_dout[0];
                    IO_NSTEP:   nstep   <= io_dout[NSTEP_W-1:0];
                    default: ;
                endcase
            end
            if (io_we && io_addr == IO_CYC) cyc_cnt <= '0;
            else if (cpu_rise_c)            cyc_cnt <= cyc_cnt + DW'(1);
        end
    end

    // View mode, address counter, channel select and display scan
    logic [ADDR_CNT_W-1:0] acnt;
    logic [CW-1:0]         ch_sel;
    logic [SCAN_BITS-1:0]  scan;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            check  <= VIEW_IO;
            acnt   <= '0;
            ch_sel <= '0;
            scan   <= '0;
        end else begin
            scan <= scan + SCAN_BITS'(1);
            if (run_s || step_p) check <= VIEW_IO;
            else if (valid_pn)   check <= check - 2'd1;
            if (step_p) begin
                acnt   <= '0;
                ch_sel <= '0;
            end else begin
                if (check == VIEW_RF || check == VIEW_MEM) begin
                    if (next_pn)      acnt <= acnt + ADDR_CNT_W'(1);
                    else if (prev_pn) acnt <= acnt - ADDR_CNT_W'(1);
                end
                if (check == VIEW_CH) begin
                    if (next_pn)
                        ch_sel <= (ch_sel == CW'(NCH - 1)) ? '0 : ch_sel + CW'(1);
                    else if (prev_pn)
                        ch_sel <= (ch_sel == '0) ? CW'(NCH - 1) : ch_sel - CW'(1);
                end
            end
        end
    end

    // Display and IO read muxes
    logic [DW-1:0]   out1_c;
    logic [PADW-1:0] disp_c;

    always_comb begin
        out0      = out0_r;
        out1_c    = out1_r;
        m_rf_addr = {3'b000, acnt};
        case (check)
            VIEW_RF: begin
                out0   = acnt;
                out1_c = rf_data;
            end
            VIEW_MEM: begin
                out0      = acnt;
                out1_c    = m_data;
                m_rf_addr = {in_sync[4:2], acnt};
            end
            VIEW_CH: begin
                out0   = 5'(ch_sel);
                out1_c = dbg_bus[ch_sel*DW +: DW];
            end
            default: ;
        endcase
    end

    assign an     = scan[SCAN_BITS-1 -: AW];
    assign disp_c = PADW'(out1_c);
    assign seg    = disp_c[an*4 +: 4];

    always_comb begin
        io_din = '0;
        case (io_addr)
            IO_IN:      io_din = DW'(in_sync);
            IO_VALID:   io_din = DW'(valid_s);
            IO_BP_ADDR: io_din = bp_addr;
            IO_BP_CTRL: io_din = DW'({halted, bp_en});
            IO_CYC:     io_din = cyc_cnt;
            IO_NSTEP:   io_din = DW'(nstep);
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pdu_bp.sv
// Randomised self-checking bench for pdu_bp with an in-bench behavioural model.
module tb_pdu_bp;

    localparam int unsigned DW  = 32;
    localparam int unsigned NCH = 16;
    localparam int unsigned NDIG = 8;
    localparam int unsigned SB  = 6;
    localparam int unsigned AW  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              run, step, valid;
    logic [4:0]        in;
    logic              clk_cpu, halted, ready;
    logic [1:0]        check;
    logic [4:0]        out0;
    logic [AW-1:0]     an;
    logic [3:0]        seg;
    logic [7:0]        io_addr;
    logic [DW-1:0]     io_dout, io_din, rf_data, m_data, pc;
    logic              io_we;
    logic [7:0]        m_rf_addr;
    logic [NCH*DW-1:0] dbg_bus;

    always #5 clk = ~clk;

    pdu_bp #(.DW(DW), .NCH(NCH), .NDIG(NDIG), .SCAN_BITS(SB)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .valid(valid), .in(in),
        .clk_cpu(clk_cpu), .halted(halted), .check(check), .out0(out0), .ready(ready),
        .an(an), .seg(seg), .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we),
        .io_din(io_din), .m_rf_addr(m_rf_addr), .rf_data(rf_data), .m_data(m_data),
        .pc(pc), .dbg_bus(dbg_bus)
    );

    // Behavioural model state
    logic [7:0]    dl [3];          // input delay line, [1] = synchronised view
    bit            m_run, m_stp, m_hlt;
    logic          m_clk, m_skip, m_rise;
    int            m_rem, m_ch, m_scan;
    logic [DW-1:0] m_cyc, m_out1r, m_bp;
    logic [4:0]    m_out0r, m_acnt;
    logic          m_ready, m_bpen;
    logic [7:0]    m_nstep;
    logic [1:0]    m_check;

    int vectors = 0;
    int miscompares = 0;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) dl[i] = 8'h00;
        m_run = 0; m_stp = 0; m_hlt = 0;
        m_clk = 0; m_skip = 0; m_rise = 0; m_rem = 0;
        m_ch = 0; m_scan = 0; m_cyc = '0; m_out1r = 32'h1234_5678; m_bp = '0;
        m_out0r = 5'h1f; m_acnt = '0; m_ready = 1; m_bpen = 0; m_nstep = 8'd1;
        m_check = 2'b00;
    endtask

    task automatic model_edge();
        logic [7:0] cur, old;
        bit run_l, step_p, valid_pn, nx, pv, hit;
        logic nclk;
        cur = dl[1]; old = dl[2];
        run_l = cur[0]; step_p = cur[1] & ~old[1];
        valid_pn = cur[2] ^ old[2]; nx = cur[3] ^ old[3]; pv = cur[4] ^ old[4];
        hit = m_bpen && (pc == m_bp) && !m_skip;
        nclk = 1'b0;   // the CPU clock only ever rises while running/stepping
        if (m_run) begin
            if (!run_l) m_run = 0;
            else if (m_clk) begin
                if (hit) begin m_run = 0; m_hlt = 1; end
            end else begin nclk = 1'b1; m_skip = 0; end
        end else if (m_stp) begin
            if (m_clk) begin
                if (hit) begin m_stp = 0; m_hlt = 1; end
                else if (m_rem == 1) m_stp = 0;
                m_rem--;
            end else begin nclk = 1'b1; m_skip = 0; end
        end else if (m_hlt) begin
            if (!run_l && !step_p) m_hlt = 0;
        end else begin
            if (run_l) begin m_run = 1; m_skip = 1; end
            else if (step_p) begin
                m_stp = 1; m_skip = 1;
                m_rem = (m_nstep == 0) ? 1 : int'(m_nstep);
            end
        end
        m_rise = !m_clk && nclk;
        m_clk = nclk;
        if (io_we && io_addr == 8'h1c) m_cyc = '0;
        else if (m_rise) m_cyc = m_cyc + 1;
        if (io_we) begin
            case (io_addr)
                8'h00: m_out0r = io_dout[4:0];
                8'h04: m_ready = io_dout[0];
                8'h08: m_out1r = io_dout;
                8'h14: m_bp    = io_dout;
                8'h18: m_bpen  = io_dout[0];
                8'h20: m_nstep = io_dout[7:0];
                default: ;
            endcase
        end
        if (step_p) begin
            m_acnt = '0; m_ch = 0;
        end else begin
            if (m_check == 2'd1 || m_check == 2'd2) begin
                if (nx) m_acnt = m_acnt + 1;
                else if (pv) m_acnt = m_acnt - 1;
            end
            if (m_check == 2'd3) begin
                if (nx) m_ch = (m_ch + 1) % NCH;
                else if (pv) m_ch = (m_ch + NCH - 1) % NCH;
            end
        end
        if (run_l || step_p) m_check = 2'b00;
        else if (valid_pn) m_check = m_check - 2'd1;
        m_scan = (m_scan + 1) % (1 << SB);
        dl[2] = dl[1]; dl[1] = dl[0]; dl[0] = {in, valid, step, run};
    endtask

    task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    task automatic check_all();
        logic [DW-1:0] o1, din;
        logic [4:0] o0;
        int a;
        case (m_check)
            2'd0: begin o1 = m_out1r; o0 = m_out0r; end
            2'd1: begin o1 = rf_data; o0 = m_acnt; end
            2'd2: begin o1 = m_data;  o0 = m_acnt; end
            default: begin o1 = dbg_bus[m_ch*DW +: DW]; o0 = 5'(m_ch); end
        endcase
        a = m_scan >> (SB - AW);
        case (io_addr)
            8'h0c: din = DW'(dl[1][7:3]);
            8'h10: din = DW'(dl[1][2]);
            8'h14: din = m_bp;
            8'h18: din = DW'({m_hlt, m_bpen});
            8'h1c: din = m_cyc;
            8'h20: din = DW'(m_nstep);
            default: din = '0;
        endcase
        cmp("clk_cpu", clk_cpu, m_clk);
        cmp("halted", halted, m_hlt);
        cmp("check", check, m_check);
        cmp("out0", out0, o0);
        cmp("ready", ready, m_ready);
        cmp("an", an, a);
        cmp("seg", seg, (a * 4 < DW) ? 4'(o1 >> (a * 4)) : 4'h0);
        cmp("m_rf_addr", m_rf_addr, (m_check == 2'd2) ? {dl[1][7:5], m_acnt} : {3'b000, m_acnt});
        cmp("io_din", io_din, din);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        rf_data = $urandom; m_data = $urandom;
        for (int k = 0; k < NCH; k++) dbg_bus[k*DW +: DW] = $urandom;
        #1;
        check_all();
        if (m_rise) pc = pc + 4;
    endtask

    task automatic wr(input logic [7:0] a, input logic [DW-1:0] d);
        io_we = 1; io_addr = a; io_dout = d;
        tick();
        io_we = 0;
    endtask

    task automatic ticks_count(input int n, output int rises);
        logic prev;
        rises = 0;
        for (int i = 0; i < n; i++) begin
            prev = clk_cpu;
            tick();
            if (!prev && clk_cpu) rises++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, w;
        logic [DW-1:0] wv;
        logic [7:0] addr_tab [11];
        addr_tab = '{8'h00, 8'h04, 8'h08, 8'h0c, 8'h10, 8'h14, 8'h18, 8'h1c, 8'h20, 8'h24, 8'h3c};

        rst_n = 0; run = 0; step = 0; valid = 0; in = '0;
        io_addr = 8'h08; io_dout = '0; io_we = 0; pc = '0;
        rf_data = '0; m_data = '0; dbg_bus = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // Reset state
        cmp("rst_clk_cpu", clk_cpu, 0);
        cmp("rst_halted", halted, 0);
        cmp("rst_ready", ready, 1);
        cmp("rst_out0", out0, 5'h1f);
        cmp("rst_check", check, 0);
        check_all();

        // Scanned digits of the reset IO value 0x12345678
        for (int d = 0; d < 8; d++) begin
            w = 0;
            while (an != 3'(d) && w < 80) begin tick(); w++; end
            if (w >= 80) timeout_fail("digit_wait");
            else cmp("digit", seg, 8 - d);
        end

        // Three-step burst
        wr(8'h20, 3);
        step = 1;
        ticks_count(3, r);
        step = 0;
        ticks_count(20, w);
        cmp("step_rises", r + w, 3);
        cmp("step_halted", halted, 0);
        io_addr = 8'h1c;
        tick();
        cmp("cyc_after_step", io_din, 3);

        // Breakpoint at 0x10 while running
        wr(8'h14, 32'h10);
        wr(8'h18, 1);
        pc = '0;
        run = 1;
        w = 0;
        while (!halted && w < 60) begin tick(); w++; end
        if (w >= 60) timeout_fail("bp_wait");
        cmp("bp_clk_cpu", clk_cpu, 0);
        cmp("bp_halted", halted, 1);
        cmp("bp_pc", pc, 32'h10);
        io_addr = 8'h18;
        tick();
        cmp("bp_ctrl_read", io_din, 3);
        io_addr = 8'h1c;
        tick();
        cmp("bp_cyc", io_din, 7);

        // Resume from the breakpoint PC without re-halting
        run = 0;
        repeat (6) tick();
        cmp("resume_idle", halted, 0);
        run = 1;
        ticks_count(12, r);
        cmp("resume_halted", halted, 0);
        cmp("resume_rises", r, 5);

        // Cycle-counter clear while running
        wr(8'h1c, 0);
        cmp("cyc_clear", io_din, 0);
        repeat (4) tick();
        cmp("cyc_resume", io_din, 2);

        // Channel view, prev wraps to NCH-1, next wraps back to 0
        run = 0;
        repeat (6) tick();
        valid = 1;
        repeat (4) tick();
        cmp("view_ch", check, 3);
        in[1] = 1;
        repeat (4) tick();
        cmp("ch_prev_wrap", out0, NCH - 1);
        wv = dbg_bus[(NCH-1)*DW +: DW];
        cmp("ch_prev_seg", seg, 4'(wv >> ((m_scan >> (SB - AW)) * 4)));
        in[0] = 1;
        repeat (4) tick();
        cmp("ch_next_wrap", out0, 0);

        // Asynchronous reset in the middle of a run burst
        run = 1;
        w = 0;
        while (!(clk_cpu && !halted) && w < 40) begin tick(); w++; end
        if (w >= 40) timeout_fail("burst_wait");
        #2 rst_n = 0;
        #1 cmp("async_rst_clk_cpu", clk_cpu, 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
        run = 0;
        check_all();

        // Randomised traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 199) == 0) run = ~run;
            if ($urandom_range(0, 29) == 0) step = ~step;
            if ($urandom_range(0, 39) == 0) valid = ~valid;
            if ($urandom_range(0, 19) == 0) in[0] = ~in[0];
            if ($urandom_range(0, 19) == 0) in[1] = ~in[1];
            if ($urandom_range(0, 49) == 0) in[4:2] = 3'($urandom);
            if ($urandom_range(0, 99) == 0) pc = 4 * $urandom_range(0, 16);
            io_addr = addr_tab[$urandom_range(0, 10)];
            io_we = ($urandom_range(0, 5) == 0);
            case (io_addr)
                8'h14: io_dout = 4 * $urandom_range(0, 16);
                8'h20: io_dout = $urandom_range(0, 5);
                default: io_dout = $urandom;
            endcase
            tick();
        end
        io_we = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
